mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - MEM-stage request and data-cache bus bundle for mem_access_unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic        indirect_enable;
  logic [1:0]  mem_byte_enable;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic [15:0] rdata;
  logic        done;
  logic        stall;

  modport slave (
    input  req_valid, mem_read, mem_write, indirect_enable, mem_byte_enable,
    input  addr, wdata, dmem_resp, dmem_rdata,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output rdata, done, stall
  );

  modport master (
    output req_valid, mem_read, mem_write, indirect_enable, mem_byte_enable,
    output addr, wdata, dmem_resp, dmem_rdata,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  rdata, done, stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with optional pointer-indirect access
module mem_access_unit (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IND_FETCH, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic        request;

  assign request = bus.req_valid & (bus.mem_read | bus.mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      be_q    <= 2'b11;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.mem_byte_enable;
          we_d    = bus.mem_write;
          state_d = bus.indirect_enable ? IND_FETCH : ACCESS;
        end
      end
      IND_FETCH: begin
        if (bus.dmem_resp) begin
          addr_d  = {bus.dmem_rdata[15:1], 1'b0};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.dmem_resp) begin
          if (!we_q) begin
            rdata_d = bus.dmem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every dmem_* output comes from registers only, so it cannot move while a strobe waits for resp.
  always_comb begin
    bus.dmem_read        = 1'b0;
    bus.dmem_write       = 1'b0;
    bus.dmem_address     = addr_q;
    bus.dmem_wdata       = wdata_q;
    bus.dmem_byte_enable = be_q;
    bus.done             = 1'b0;
    bus.stall            = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall = request & ~rst;
      end
      IND_FETCH: begin
        bus.dmem_read        = 1'b1;
        bus.dmem_address     = {addr_q[15:1], 1'b0};
        bus.dmem_byte_enable = 2'b11;
        bus.stall            = 1'b1;
      end
      ACCESS: begin
        bus.dmem_read    = ~we_q;
        bus.dmem_write   = we_q;
        bus.dmem_address = (be_q == 2'b11) ? {addr_q[15:1], 1'b0} : addr_q;
        bus.stall        = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_rdata = 16'h0000;
  txn_t        exp_q[$];

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid       = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.indirect_enable = 1'b0;
    bus.mem_byte_enable = 2'b11;
    bus.addr            = 16'h0000;
    bus.wdata           = 16'h0000;
  endtask

  // Drives one instruction, serves its cache transactions from the scoreboard and
  // returns in the DONE cycle. at_done: inputs are presented while the previous op is in DONE.
  task automatic do_op(input logic rd, input logic wr, input logic ind, input logic [1:0] be,
                       input logic [15:0] a, input logic [15:0] wd, input logic [15:0] ptr,
                       input logic [15:0] rdat, input int lat, input logic keep, input logic at_done);
    txn_t        t;
    logic [15:0] eff;
    int          n;
    int          stall_cnt;
    bus.req_valid       = 1'b1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.indirect_enable = ind;
    bus.mem_byte_enable = be;
    bus.addr            = a;
    bus.wdata           = wd;
    #1;
    if (at_done) begin
      chk("done_ignores_req_stall", 32'(bus.stall), 32'd0);
      chk("done_no_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
      step();
    end
    chk("accept_stall", 32'(bus.stall), 32'd1);
    chk("accept_no_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
    eff = a;
    if (ind) begin
      exp_q.push_back('{we: 1'b0, addr: {a[15:1], 1'b0}, wdata: wd, be: 2'b11, rdat: ptr});
      eff = {ptr[15:1], 1'b0};
    end
    if (be == 2'b11) eff[0] = 1'b0;
    exp_q.push_back('{we: wr, addr: eff, wdata: wd, be: be, rdat: rdat});
    stall_cnt = 1;
    step();
    if (!keep) clear_req();
    while (exp_q.size() > 0) begin
      n = 0;
      while (!(bus.dmem_read | bus.dmem_write) && n < 20) begin
        stall_cnt += 32'(bus.stall);
        step();
        n++;
      end
      checks++;
      assert (n < 20) else begin
        errors++;
        $error("FAIL strobe_timeout observed=none expected=strobe");
      end
      t = exp_q.pop_front();
      for (int k = 1; k <= lat; k++) begin
        chk("dmem_read", 32'(bus.dmem_read), 32'(!t.we));
        chk("dmem_write", 32'(bus.dmem_write), 32'(t.we));
        chk("dmem_address", 32'(bus.dmem_address), 32'(t.addr));
        chk("dmem_byte_enable", 32'(bus.dmem_byte_enable), 32'(t.be));
        if (t.we) chk("dmem_wdata", 32'(bus.dmem_wdata), 32'(t.wdata));
        stall_cnt += 32'(bus.stall);
        if (k == lat) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = t.rdat;
        end
        step();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 16'hDEAD;
      end
    end
    if (rd && !wr) exp_rdata = rdat;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_stall", 32'(bus.stall), 32'd0);
    chk("done_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
    chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
    chk("stall_cycles", 32'(stall_cnt), 32'(1 + (ind ? 2 : 1) * lat));
  endtask

  initial begin
    clear_req();
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 16'h0000;
    rst = 1'b1;
    step();
    step();
    chk("rst_read", 32'(bus.dmem_read), 32'd0);
    chk("rst_write", 32'(bus.dmem_write), 32'd0);
    chk("rst_address", 32'(bus.dmem_address), 32'd0);
    chk("rst_wdata", 32'(bus.dmem_wdata), 32'd0);
    chk("rst_be", 32'(bus.dmem_byte_enable), 32'd3);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    #1;
    chk("rst_stall_with_req", 32'(bus.stall), 32'd0);
    clear_req();
    rst = 1'b0;
    step();

    // stray response while idle
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h7777;
    step();
    bus.dmem_resp = 1'b0;
    chk("idle_resp_done", 32'(bus.done), 32'd0);
    chk("idle_resp_stall", 32'(bus.stall), 32'd0);
    chk("idle_resp_rdata", 32'(bus.rdata), 32'd0);
    chk("idle_resp_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);

    do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h1235, 16'h0000, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0);
    step();
    chk("ldr_done_single", 32'(bus.done), 32'd0);
    do_op(1'b0, 1'b1, 1'b0, 2'b10, 16'h2001, 16'h5A00, 16'h0000, 16'hFFFF, 2, 1'b0, 1'b0);
    step();
    do_op(1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000, 16'h4001, 16'h0042, 1, 1'b0, 1'b0);
    step();
    chk("ldi_done_single", 32'(bus.done), 32'd0);
    do_op(1'b0, 1'b1, 1'b1, 2'b11, 16'h3000, 16'h1111, 16'h5000, 16'hFFFF, 2, 1'b0, 1'b0);
    step();
    do_op(1'b1, 1'b1, 1'b0, 2'b01, 16'h0101, 16'h00AB, 16'h0000, 16'hFFFF, 1, 1'b0, 1'b0);
    step();

    do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h6000, 16'h0000, 16'h0000, 16'h1357, 1, 1'b1, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h6002, 16'h0000, 16'h0000, 16'h2468, 2, 1'b1, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h6005, 16'h0000, 16'h0000, 16'h9ABC, 1, 1'b0, 1'b1);
    step();
    chk("b2b_tail_done", 32'(bus.done), 32'd0);
    chk("b2b_tail_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
    step();

    // reset in the middle of a load, then a late response
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    bus.addr      = 16'h7000;
    step();
    clear_req();
    chk("pre_rst_read", 32'(bus.dmem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_read", 32'(bus.dmem_read), 32'd0);
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    chk("async_rst_rdata", 32'(bus.rdata), 32'd0);
    chk("async_rst_address", 32'(bus.dmem_address), 32'd0);
    exp_rdata = 16'h0000;
    step();
    rst = 1'b0;
    step();
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h5555;
    step();
    bus.dmem_resp = 1'b0;
    chk("stray_done", 32'(bus.done), 32'd0);
    chk("stray_stall", 32'(bus.stall), 32'd0);
    chk("stray_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
    chk("stray_rdata", 32'(bus.rdata), 32'(exp_rdata));
    step();
    chk("stray_done_late", 32'(bus.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
